// File: rtl/mul_seq32.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One partial-product add per cycle through fulladder32; result via valid pulse.
module fulladder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        carry_i,
    output logic [31:0] sum_o,
    output logic        carry_o
);
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, carry_i};
endmodule

module mul_seq32 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_e;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [32:0] acc_hi_q, acc_hi_d;
    logic        neg_q, neg_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] result_q, result_d;

    logic [31:0] fa_b, fa_sum;
    logic        fa_carry;
    logic        a_neg, b_neg;
    logic [64:0] shifted;
    logic [63:0] prod, prod_fin;

    assign fa_b = mplier_q[0] ? mcand_q : 32'h0;

    fulladder32 u_fa (
        .a_i     (acc_hi_q[31:0]),
        .b_i     (fa_b),
        .carry_i (1'b0),
        .sum_o   (fa_sum),
        .carry_o (fa_carry)
    );

    // Only signed operands contribute a sign; MUL is taken as unsigned (low half is identical).
    assign a_neg    = a_i[31] && (op_i == OP_MULH || op_i == OP_MULHSU);
    assign b_neg    = b_i[31] && (op_i == OP_MULH);
    assign shifted  = {fa_carry, fa_sum, mplier_q} >> 1;
    assign prod     = {acc_hi_q[31:0], mplier_q};
    assign prod_fin = neg_q ? (64'h0 - prod) : prod;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_hi_d = acc_hi_q;
        neg_d    = neg_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (valid_i && !kill_i) begin
                    mcand_d  = a_neg ? (32'h0 - a_i) : a_i;
                    mplier_d = b_neg ? (32'h0 - b_i) : b_i;
                    neg_d    = a_neg ^ b_neg;
                    op_d     = op_i;
                    acc_hi_d = '0;
                    count_d  = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                {acc_hi_d, mplier_d} = shifted;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31)
                    state_d = SIGN;
            end
            SIGN: begin
                {acc_hi_d[31:0], mplier_d} = prod_fin;
                result_d = (op_q == OP_MUL) ? prod_fin[31:0] : prod_fin[63:32];
                state_d  = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flush wins over everything except a DONE already on the output.
        if (kill_i && state_q != IDLE) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_hi_q <= acc_hi_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = !ready_o;
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;
endmodule

// File: tb/tb_mul_seq32.sv
// Directed bench for mul_seq32: hand-computed products, latency, kill and reset.
module tb_mul_seq32;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        kill_i = 1'b0;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int errors = 0;
    int checks = 0;

    mul_seq32 dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .kill_i   (kill_i),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue in cycle 0, wait for valid_o, check its cycle and the result.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        cyc = 1;
        while (!valid_o && cyc < 60) begin
            step();
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'd34);
        chk(tag, result_o, exp);
        step();
    endtask

    initial begin
        logic ok;
        int   cyc;
        #2;
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_result", result_o, 32'h0);
        rst_ni = 1'b1;
        step();

        run_op("mulhu_ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mul_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mul_min", 2'b00, 32'h80000000, 32'h80000000, 32'h00000000);
        run_op("mulhsu_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mul_pat", 2'b00, 32'h12345678, 32'h00000010, 32'h23456780);
        run_op("mulhu_pat", 2'b11, 32'h12345678, 32'h00000010, 32'h00000001);
        run_op("mulh_m1min", 2'b01, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
        run_op("mulhsu_min2", 2'b10, 32'h80000000, 32'h00000002, 32'hFFFFFFFF);

        // MUL 7 x -3, ready low in 1..34, stray request in cycle 5 ignored
        op_i = 2'b00; a_i = 32'd7; b_i = 32'hFFFFFFFD; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        ok = 1'b1;
        cyc = 1;
        while (!valid_o && cyc < 60) begin
            if (ready_o) ok = 1'b0;
            if (cyc == 5) begin
                op_i = 2'b11; a_i = 32'h55; b_i = 32'h66; valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            step();
            cyc++;
        end
        valid_i = 1'b0;
        if (ready_o) ok = 1'b0;
        chk("t4_ready_low", {31'b0, ok}, 32'd1);
        chk("t4_lat", 32'(cyc), 32'd34);
        chk("t4_result", result_o, 32'hFFFFFFEB);
        // kill in the DONE cycle keeps this valid pulse
        kill_i = 1'b1;
        #1;
        chk("t4_kill_done_valid", {31'b0, valid_o}, 32'd1);
        step();
        kill_i = 1'b0;
        chk("t4_idle_after", {31'b0, ready_o}, 32'd1);
        chk("t4_hold", result_o, 32'hFFFFFFEB);

        // kill in IDLE blocks the same-cycle accept
        op_i = 2'b00; a_i = 32'd9; b_i = 32'd9; valid_i = 1'b1; kill_i = 1'b1;
        step();
        valid_i = 1'b0; kill_i = 1'b0;
        chk("kill_idle_ready", {31'b0, ready_o}, 32'd1);

        // MUL 5x6 killed in cycle 10
        op_i = 2'b00; a_i = 32'd5; b_i = 32'd6; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        ok = 1'b1;
        for (int c = 1; c < 10; c++) begin
            if (valid_o) ok = 1'b0;
            step();
        end
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        chk("t5_no_valid", {31'b0, ok}, 32'd1);
        chk("t5_ready11", {31'b0, ready_o}, 32'd1);
        chk("t5_valid11", {31'b0, valid_o}, 32'd0);
        chk("t5_result_kept", result_o, 32'hFFFFFFEB);
        run_op("t5_mul56", 2'b00, 32'd5, 32'd6, 32'd30);

        // async reset in cycle 20 of a MULH
        op_i = 2'b01; a_i = 32'hFFFFFFFE; b_i = 32'd3; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        for (int c = 1; c < 20; c++) step();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_ready", {31'b0, ready_o}, 32'd1);
        chk("t6_valid", {31'b0, valid_o}, 32'd0);
        chk("t6_result", result_o, 32'h0);
        step();
        rst_ni = 1'b1;
        step();
        run_op("t6_mulh", 2'b01, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
